pipeline_ctrl: RTL and testbench

Hazard and stall controller for the vector-encryption CPU pipeline. Drives the `stop` of the PC and IF_ID register, the flush of IF_ID, and bubble insertion into ID_EX. Handles taken branches, load-use hazards and multi-cycle vector operations through a request/ack/done handshake with the vector unit. Keeps a saturating stall-cycle counter for performance debug.

---
 rtl/pipeline_ctrl_pkg.sv | 14 +
 rtl/pipeline_ctrl_hazard_detect.sv | 24 ++
 rtl/pipeline_ctrl.sv | 159 +++++++++++++++
 tb/tb_pipeline_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and default widths for the pipeline hazard/stall controller.
package pipeline_ctrl_pkg;

  localparam int unsigned DEF_REG_AW = 4;
  localparam int unsigned DEF_CNT_W  = 16;

  typedef enum logic [1:0] {
    RUN,
    LU_STALL,
    VEC_ISSUE,
    VEC_BUSY
  } ctrl_state_t;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard comparator: the ID instruction reads a register that a load in EX writes.
module hazard_detect
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW = DEF_REG_AW
) (
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              ex_valid,
  input  logic              ex_is_load,
  input  logic [REG_AW-1:0] ex_rd,
  output logic              lu_haz
);

  // Register 0 is hardwired, so a load targeting it never creates a dependency.
  always_comb begin
    lu_haz = ex_valid & ex_is_load & (ex_rd != '0) & id_valid &
             ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and stall controller: branch flush, load-use stall, vector-unit handshake
// with timeout, and a saturating stall-cycle counter.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW      = DEF_REG_AW,
  parameter int unsigned LOAD_LAT    = 1,
  parameter int unsigned VEC_TIMEOUT = 255,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              id_is_vec,
  input  logic              ex_valid,
  input  logic              ex_is_load,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              branch_taken,
  input  logic              vec_ack,
  input  logic              vec_done,
  output logic              pc_stop,
  output logic              if_id_stop,
  output logic              if_id_flush,
  output logic              id_ex_bubble,
  output logic              vec_req,
  output logic              vec_err,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int unsigned LAT_W = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;
  localparam int unsigned TMO_W = $clog2(VEC_TIMEOUT + 1);

  ctrl_state_t      state_q, state_d;
  logic [LAT_W-1:0] lu_cnt_q, lu_cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             vec_req_q, vec_req_d;
  logic             vec_err_q, vec_err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic lu_haz;
  logic tmo_hit;
  logic vec_release;

  hazard_detect #(.REG_AW(REG_AW)) u_hazard_detect (
    .id_valid   (id_valid),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .ex_valid   (ex_valid),
    .ex_is_load (ex_is_load),
    .ex_rd      (ex_rd),
    .lu_haz     (lu_haz)
  );

  // Release happens in the VEC_TIMEOUT-th busy cycle at the latest; done wins over timeout.
  assign tmo_hit     = (tmo_q == TMO_W'(VEC_TIMEOUT - 1));
  assign vec_release = (state_q == VEC_BUSY) & (vec_done | tmo_hit);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= RUN;
      lu_cnt_q    <= '0;
      tmo_q       <= '0;
      vec_req_q   <= 1'b0;
      vec_err_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      lu_cnt_q    <= lu_cnt_d;
      tmo_q       <= tmo_d;
      vec_req_q   <= vec_req_d;
      vec_err_q   <= vec_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    lu_cnt_d    = lu_cnt_q;
    tmo_d       = tmo_q;
    vec_req_d   = vec_req_q;
    vec_err_d   = vec_err_q;
    stall_cnt_d = stall_cnt_q;
    unique case (state_q)
      RUN: begin
        if (branch_taken) begin
          state_d = RUN;
        end else if (lu_haz) begin
          if (LOAD_LAT > 1) begin
            state_d  = LU_STALL;
            lu_cnt_d = LAT_W'(LOAD_LAT - 1);
          end
        end else if (id_valid && id_is_vec) begin
          state_d   = VEC_ISSUE;
          vec_req_d = 1'b1;
        end
      end
      LU_STALL: begin
        lu_cnt_d = lu_cnt_q - LAT_W'(1);
        if (lu_cnt_q == LAT_W'(1)) state_d = RUN;
      end
      VEC_ISSUE: begin
        if (vec_ack) begin
          state_d   = VEC_BUSY;
          vec_req_d = 1'b0;
          tmo_d     = '0;
        end
      end
      VEC_BUSY: begin
        tmo_d = tmo_q + TMO_W'(1);
        if (vec_release) begin
          state_d = RUN;
          if (!vec_done) vec_err_d = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
    if (pc_stop && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_comb begin
    pc_stop      = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    if (reset) begin
      unique case (state_q)
        RUN: begin
          if (branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
          end else if (lu_haz || (id_valid && id_is_vec)) begin
            pc_stop      = 1'b1;
            id_ex_bubble = 1'b1;
          end
        end
        LU_STALL, VEC_ISSUE: begin
          pc_stop      = 1'b1;
          id_ex_bubble = 1'b1;
        end
        // Release cycle: fetch resumes but the vector op never enters EX.
        VEC_BUSY: begin
          pc_stop      = ~vec_release;
          id_ex_bubble = 1'b1;
        end
        default: ;
      endcase
    end
    if_id_stop = pc_stop;
    vec_req    = vec_req_q & reset;
    vec_err    = vec_err_q & reset;
    stall_cnt  = reset ? stall_cnt_q : '0;
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed vector table, hand-written
// vector/timeout/reset sequences and randomized traffic against a reference model.
module tb_pipeline_ctrl;

  localparam int unsigned REG_AW      = 4;
  localparam int unsigned LOAD_LAT    = 2;
  localparam int unsigned VEC_TIMEOUT = 6;
  localparam int unsigned CNT_W       = 16;

  typedef struct {
    logic              rst;
    logic              idv;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              u1;
    logic              u2;
    logic              vec;
    logic              exv;
    logic              exl;
    logic [REG_AW-1:0] rd;
    logic              br;
    logic              ack;
    logic              done;
  } in_t;

  typedef struct {
    in_t  i;
    logic stop;
    logic flush;
    logic bub;
    logic req;
    logic err;
    int   cnt;
  } vec_t;

  logic              clk;
  logic              reset;
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic              id_is_vec;
  logic              ex_valid;
  logic              ex_is_load;
  logic [REG_AW-1:0] ex_rd;
  logic              branch_taken;
  logic              vec_ack;
  logic              vec_done;
  logic              pc_stop;
  logic              if_id_stop;
  logic              if_id_flush;
  logic              id_ex_bubble;
  logic              vec_req;
  logic              vec_err;
  logic [CNT_W-1:0]  stall_cnt;

  pipeline_ctrl #(
    .REG_AW      (REG_AW),
    .LOAD_LAT    (LOAD_LAT),
    .VEC_TIMEOUT (VEC_TIMEOUT),
    .CNT_W       (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .id_is_vec    (id_is_vec),
    .ex_valid     (ex_valid),
    .ex_is_load   (ex_is_load),
    .ex_rd        (ex_rd),
    .branch_taken (branch_taken),
    .vec_ack      (vec_ack),
    .vec_done     (vec_done),
    .pc_stop      (pc_stop),
    .if_id_stop   (if_id_stop),
    .if_id_flush  (if_id_flush),
    .id_ex_bubble (id_ex_bubble),
    .vec_req      (vec_req),
    .vec_err      (vec_err),
    .stall_cnt    (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pending stall cycles, vector phase flags, busy-cycle tally.
  int m_lu_left = 0;
  bit m_wait    = 0;
  bit m_busy    = 0;
  int m_busy_n  = 0;
  bit m_err     = 0;
  int m_cnt     = 0;
  bit e_stop, e_flush, e_bub, e_req, e_err;
  int e_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic bit model_haz(input in_t x);
    bit hit1, hit2;
    hit1 = x.u1 && (x.rs1 == x.rd);
    hit2 = x.u2 && (x.rs2 == x.rd);
    return x.idv && x.exv && x.exl && (x.rd != 0) && (hit1 || hit2);
  endfunction

  function automatic void model_step(input in_t x);
    e_stop = 0; e_flush = 0; e_bub = 0;
    if (!x.rst) begin
      e_req = 0; e_err = 0; e_cnt = 0;
      m_lu_left = 0; m_wait = 0; m_busy = 0; m_busy_n = 0; m_err = 0; m_cnt = 0;
      return;
    end
    e_req = m_wait;
    e_err = m_err;
    e_cnt = m_cnt;
    if (m_lu_left > 0) begin
      e_stop = 1; e_bub = 1;
      m_lu_left--;
    end else if (m_wait) begin
      e_stop = 1; e_bub = 1;
      if (x.ack) begin m_wait = 0; m_busy = 1; m_busy_n = 0; end
    end else if (m_busy) begin
      e_bub = 1;
      if (x.done || (m_busy_n + 1 == int'(VEC_TIMEOUT))) begin
        if (!x.done) m_err = 1;
        m_busy = 0;
      end else begin
        e_stop = 1;
        m_busy_n++;
      end
    end else if (x.br) begin
      e_flush = 1; e_bub = 1;
    end else if (model_haz(x)) begin
      e_stop = 1; e_bub = 1;
      m_lu_left = int'(LOAD_LAT) - 1;
    end else if (x.idv && x.vec) begin
      e_stop = 1; e_bub = 1;
      m_wait = 1;
    end
    if (e_stop && m_cnt < (1 << CNT_W) - 1) m_cnt++;
  endfunction

  task automatic apply(input in_t x);
    reset = x.rst; id_valid = x.idv; id_rs1 = x.rs1; id_rs2 = x.rs2;
    id_use_rs1 = x.u1; id_use_rs2 = x.u2; id_is_vec = x.vec;
    ex_valid = x.exv; ex_is_load = x.exl; ex_rd = x.rd;
    branch_taken = x.br; vec_ack = x.ack; vec_done = x.done;
  endtask

  // One cycle checked against the reference model; starts and ends 1 time unit after posedge.
  task automatic mcyc(input in_t x, input string tag);
    apply(x);
    @(negedge clk);
    model_step(x);
    chk({tag, ".pc_stop"},      32'(pc_stop),      32'(e_stop));
    chk({tag, ".if_id_stop"},   32'(if_id_stop),   32'(e_stop));
    chk({tag, ".if_id_flush"},  32'(if_id_flush),  32'(e_flush));
    chk({tag, ".id_ex_bubble"}, 32'(id_ex_bubble), 32'(e_bub));
    chk({tag, ".vec_req"},      32'(vec_req),      32'(e_req));
    chk({tag, ".vec_err"},      32'(vec_err),      32'(e_err));
    chk({tag, ".stall_cnt"},    32'(stall_cnt),    32'(e_cnt));
    @(posedge clk); #1;
  endtask

  function automatic in_t idle_in();
    in_t x;
    x = '{rst:1, idv:0, rs1:0, rs2:0, u1:0, u2:0, vec:0, exv:0, exl:0, rd:0, br:0, ack:0, done:0};
    return x;
  endfunction

  function automatic vec_t row(input bit rst, idv, input int rs1, rs2, input bit u1, u2, vec,
                               exv, exl, input int rd, input bit br,
                               input bit stop, flush, bub, req, err, input int cnt);
    vec_t r;
    r.i = '{rst:rst, idv:idv, rs1:REG_AW'(rs1), rs2:REG_AW'(rs2), u1:u1, u2:u2, vec:vec,
            exv:exv, exl:exl, rd:REG_AW'(rd), br:br, ack:0, done:0};
    r.stop = stop; r.flush = flush; r.bub = bub; r.req = req; r.err = err; r.cnt = cnt;
    return r;
  endfunction

  vec_t tab[$];
  in_t  x;
  int   cnt0;

  initial begin
    apply(idle_in());
    reset = 1'b0;
    //               rst idv rs1 rs2 u1 u2 vec exv exl rd br | stop flush bub req err cnt
    tab.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
    tab.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
    tab.push_back(row(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
    tab.push_back(row(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 1, 1, 0, 0, 0));
    tab.push_back(row(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));
    tab.push_back(row(1, 1, 3, 0, 1, 0, 0, 1, 1, 3, 0,  1, 0, 1, 0, 0, 0));
    tab.push_back(row(1, 1, 3, 0, 1, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 0, 1));
    tab.push_back(row(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 2));
    tab.push_back(row(1, 1, 0, 0, 1, 0, 0, 1, 1, 0, 0,  0, 0, 0, 0, 0, 2));
    tab.push_back(row(1, 1, 0, 5, 0, 1, 0, 1, 1, 5, 1,  0, 1, 1, 0, 0, 2));
    tab.push_back(row(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 2));
    tab.push_back(row(1, 1, 7, 7, 0, 1, 0, 1, 1, 7, 0,  1, 0, 1, 0, 0, 2));
    tab.push_back(row(1, 1, 7, 7, 0, 1, 0, 0, 0, 0, 0,  1, 0, 1, 0, 0, 3));
    tab.push_back(row(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 4));
    tab.push_back(row(1, 0, 2, 0, 1, 0, 0, 1, 1, 2, 0,  0, 0, 0, 0, 0, 4));
    tab.push_back(row(1, 1, 2, 0, 0, 0, 0, 1, 1, 2, 0,  0, 0, 0, 0, 0, 4));

    @(posedge clk); #1;
    foreach (tab[k]) begin
      apply(tab[k].i);
      @(negedge clk);
      model_step(tab[k].i);
      chk($sformatf("tab%0d.pc_stop", k),      32'(pc_stop),      32'(tab[k].stop));
      chk($sformatf("tab%0d.if_id_stop", k),   32'(if_id_stop),   32'(tab[k].stop));
      chk($sformatf("tab%0d.if_id_flush", k),  32'(if_id_flush),  32'(tab[k].flush));
      chk($sformatf("tab%0d.id_ex_bubble", k), 32'(id_ex_bubble), 32'(tab[k].bub));
      chk($sformatf("tab%0d.vec_req", k),      32'(vec_req),      32'(tab[k].req));
      chk($sformatf("tab%0d.vec_err", k),      32'(vec_err),      32'(tab[k].err));
      chk($sformatf("tab%0d.stall_cnt", k),    32'(stall_cnt),    32'(tab[k].cnt));
      @(posedge clk); #1;
    end

    // Vector op: done ignored while issuing, ack on third request cycle, done on fifth busy cycle.
    cnt0 = int'(stall_cnt);
    x = idle_in(); x.idv = 1; x.vec = 1;
    mcyc(x, "vec_detect");
    x.done = 1; mcyc(x, "vec_issue1");
    x.done = 0; mcyc(x, "vec_issue2");
    x.ack = 1;  mcyc(x, "vec_issue3");
    x.ack = 0;
    for (int i = 0; i < 4; i++) mcyc(x, "vec_busy");
    x.done = 1; mcyc(x, "vec_release");
    mcyc(idle_in(), "vec_after");
    chk("vec_stall_total", 32'(int'(stall_cnt) - cnt0), 32'd8);
    chk("vec_err_clean", 32'(vec_err), 32'd0);

    // Same-cycle ack, then done coincident with the timeout cycle: no error.
    x = idle_in(); x.idv = 1; x.vec = 1;
    mcyc(x, "vcoin_detect");
    x.ack = 1; mcyc(x, "vcoin_issue");
    x.ack = 0;
    for (int i = 0; i < int'(VEC_TIMEOUT) - 1; i++) mcyc(x, "vcoin_busy");
    x.done = 1; mcyc(x, "vcoin_release");
    mcyc(idle_in(), "vcoin_after");
    chk("vcoin_err", 32'(vec_err), 32'd0);

    // Timeout without done: sticky error and back in RUN.
    x = idle_in(); x.idv = 1; x.vec = 1;
    mcyc(x, "tmo_detect");
    x.ack = 1; mcyc(x, "tmo_issue");
    x.ack = 0;
    for (int i = 0; i < int'(VEC_TIMEOUT); i++) mcyc(x, "tmo_busy");
    mcyc(idle_in(), "tmo_after");
    chk("tmo_err_set", 32'(vec_err), 32'd1);
    chk("tmo_run_idle", 32'(pc_stop), 32'd0);

    // Reset in the middle of VEC_BUSY clears everything including the sticky error.
    x = idle_in(); x.idv = 1; x.vec = 1;
    mcyc(x, "rst_detect");
    mcyc(x, "rst_issue");
    x.ack = 1; mcyc(x, "rst_ack");
    x.ack = 0; mcyc(x, "rst_busy");
    x.rst = 0; mcyc(x, "rst_low");
    x = idle_in(); mcyc(x, "rst_release");
    chk("rst_vec_req", 32'(vec_req), 32'd0);
    chk("rst_vec_err", 32'(vec_err), 32'd0);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);

    for (int i = 0; i < 3000; i++) begin
      x.rst  = ($urandom_range(0, 63) != 0);
      x.idv  = ($urandom_range(0, 3) != 0);
      x.rs1  = REG_AW'($urandom_range(0, 3));
      x.rs2  = REG_AW'($urandom_range(0, 3));
      x.u1   = 1'($urandom);
      x.u2   = 1'($urandom);
      x.vec  = ($urandom_range(0, 7) == 0);
      x.exv  = 1'($urandom);
      x.exl  = 1'($urandom);
      x.rd   = REG_AW'($urandom_range(0, 3));
      x.br   = ($urandom_range(0, 7) == 0);
      x.ack  = ($urandom_range(0, 2) == 0);
      x.done = ($urandom_range(0, 5) == 0);
      mcyc(x, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
